// File: rtl/uart_tx_multi.sv
// UART transmitter: runtime divisor, parity and stop-bit select, valid/ready input buffer.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_multi #(
    parameter  int DATA_BITS  = 8,
    parameter  int DIV_W      = 24,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 uart_clock,
    input  logic                 uart_reset,
    input  logic                 uart_valid,
    input  logic [DATA_BITS-1:0] uart_d_in,
    output logic                 uart_ready,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 uart_d_out,
    output logic                 uart_busy,
    output logic [LVL_W-1:0]     fifo_level
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_cnt_reg, div_cnt_next;
    logic [DIV_W-1:0]     div_lat_reg, div_lat_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [1:0]           mode_reg, mode_next;
    logic                 two_stop_reg, two_stop_next;
    logic                 par_reg, par_next;
    logic                 ready_reg;
    logic                 push, pop, load, bit_end, buf_nonempty;
    logic [DATA_BITS-1:0] head;

    assign push       = uart_valid && ready_reg;
    assign uart_ready = ready_reg;
    assign uart_busy  = (state_reg != S_IDLE) || buf_nonempty;

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        div_lat_next  = div_lat_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        mode_next     = mode_reg;
        two_stop_next = two_stop_reg;
        par_next      = par_reg;
        load          = 1'b0;
        pop           = 1'b0;
        bit_end       = (div_cnt_reg == div_lat_reg);

        case (state_reg)
            S_IDLE: load = buf_nonempty;
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = (mode_reg != 2'b00) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next   = S_STOP;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    div_cnt_next = '0;
                    if (bit_cnt_reg == BW'(two_stop_reg)) begin
                        bit_cnt_next = '0;
                        state_next   = S_IDLE;
                        load         = buf_nonempty;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Frame setup shared by IDLE and the gapless STOP->START path.
        if (load) begin
            pop           = 1'b1;
            state_next    = S_START;
            div_cnt_next  = '0;
            bit_cnt_next  = '0;
            shift_next    = head;
            div_lat_next  = baud_div;
            mode_next     = parity_mode;
            two_stop_next = two_stop;
            case (parity_mode)
                2'b01:   par_next = ^head;
                2'b10:   par_next = ~^head;
                default: par_next = 1'b0;
            endcase
        end
    end

    always_comb begin
        uart_d_out = 1'b1;
        case (state_reg)
            S_START:  uart_d_out = 1'b0;
            S_DATA:   uart_d_out = shift_reg[0];
            S_PARITY: uart_d_out = par_reg;
            default:  uart_d_out = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            state_reg    <= S_IDLE;
            div_cnt_reg  <= '0;
            div_lat_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            mode_reg     <= 2'b00;
            two_stop_reg <= 1'b0;
            par_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            div_lat_reg  <= div_lat_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            mode_reg     <= mode_next;
            two_stop_reg <= two_stop_next;
            par_reg      <= par_next;
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_BITS-1:0] mem_reg [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]     count_reg, count_next;

    assign head         = mem_reg[rd_ptr_reg];
    assign buf_nonempty = (count_reg != '0);
    assign fifo_level   = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge uart_clock) begin
        if (push) mem_reg[wr_ptr_reg] <= uart_d_in;
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
            ready_reg <= (count_next != LVL_W'(FIFO_DEPTH));
        end
    end
`else
    logic [DATA_BITS-1:0] hold_reg;
    logic                 full_reg, full_next;

    assign head         = hold_reg;
    assign buf_nonempty = full_reg;
    assign fifo_level   = LVL_W'(full_reg);
    assign full_next    = push ? 1'b1 : (pop ? 1'b0 : full_reg);

    always_ff @(posedge uart_clock) begin
        if (!uart_reset) begin
            hold_reg  <= '0;
            full_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            if (push) hold_reg <= uart_d_in;
            full_reg  <= full_next;
            ready_reg <= !full_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_multi.sv
// Directed bench for uart_tx_multi: frame shapes, parity, stop bits, streaming, reset, buffer limits.
module tb_uart_tx_multi;

    logic        clk = 1'b0;
    logic        uart_reset;
    logic        uart_valid;
    logic [7:0]  uart_d_in;
    logic        uart_ready;
    logic [23:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        uart_d_out;
    logic        uart_busy;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    logic samp    [0:4099];
    logic busy_s  [0:4099];
    logic ready_s [0:4099];
    logic [2:0] level_s [0:4099];
    logic [7:0] tx_q [$];

    uart_tx_multi #(.DATA_BITS(8), .DIV_W(24), .FIFO_DEPTH(4)) dut (
        .uart_clock (clk),
        .uart_reset (uart_reset),
        .uart_valid (uart_valid),
        .uart_d_in  (uart_d_in),
        .uart_ready (uart_ready),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .uart_d_out (uart_d_out),
        .uart_busy  (uart_busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        if (tx_q.size() > 0) begin
            uart_valid = 1'b1;
            uart_d_in  = tx_q[0];
        end else begin
            uart_valid = 1'b0;
            uart_d_in  = 8'h00;
        end
    endtask

    // Records one sample per clock, then advances; pops the queue on each accepted word.
    task automatic capture(input int n, input int chg_at, input logic [23:0] chg_val);
        logic acc;
        for (int k = 0; k < n; k++) begin
            samp[k]    = uart_d_out;
            busy_s[k]  = uart_busy;
            ready_s[k] = uart_ready;
            level_s[k] = fifo_level;
            if (k == chg_at) baud_div = chg_val;
            acc = uart_valid && uart_ready;
            tick();
            if (acc) void'(tx_q.pop_front());
            drive_q();
        end
    endtask

    // bits[0] is the start bit; each bit must hold for exactly 'period' samples.
    task automatic expect_frame(input string tag, input int start, input logic [15:0] bits,
                                input int nbits, input int period);
        int hits;
        for (int b = 0; b < nbits; b++) begin
            hits = 0;
            for (int c = 0; c < period; c++)
                if (samp[start + b*period + c] === bits[b]) hits++;
            check($sformatf("%s bit%0d clocks", tag, b), hits, period);
        end
    endtask

    task automatic do_reset();
        uart_reset = 1'b0;
        tick();
        tick();
        uart_reset = 1'b1;
        tick();
    endtask

    initial begin
        int waited;
        logic prev_ready;
        uart_reset  = 1'b0;
        uart_valid  = 1'b0;
        uart_d_in   = 8'h00;
        baud_div    = 24'd9;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        tick();
        tick();
        check("reset d_out", uart_d_out, 1);
        check("reset ready", uart_ready, 1);
        check("reset busy", uart_busy, 0);
        check("reset level", fifo_level, 0);
        uart_reset = 1'b1;
        tick();

        // 8N1 0xA5, 10 clocks/bit
        tx_q = {8'hA5};
        drive_q();
        capture(103, -1, 24'd0);
        check("a5 latency idle", samp[1], 1);
        check("a5 busy early", busy_s[1], 1);
        expect_frame("a5", 2, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 10);
        check("a5 busy last", busy_s[101], 1);
        check("a5 busy drop", busy_s[102], 0);

        // Even parity on 0x07 -> 1
        parity_mode = 2'b01;
        tx_q = {8'h07};
        drive_q();
        capture(113, -1, 24'd0);
        expect_frame("even", 2, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 10);
        check("even busy drop", busy_s[112], 0);

        // Odd parity on 0x07 -> 0, two stop bits, 120 clocks
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        tx_q = {8'h07};
        drive_q();
        capture(123, -1, 24'd0);
        expect_frame("odd2", 2, {4'd0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 10);
        check("odd2 busy last", busy_s[121], 1);
        check("odd2 busy drop", busy_s[122], 0);

        // Space parity forces a 0 parity bit
        parity_mode = 2'b11;
        two_stop    = 1'b0;
        baud_div    = 24'd0;
        tx_q = {8'hFF};
        drive_q();
        capture(14, -1, 24'd0);
        expect_frame("space", 2, {5'd0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 1);

        // Streaming 0x55 then 0xAA at 1 clock/bit: no idle gap
        parity_mode = 2'b00;
        tx_q = {8'h55, 8'hAA};
        drive_q();
        capture(23, -1, 24'd0);
        expect_frame("b2b first", 2, {6'd0, 1'b1, 8'h55, 1'b0}, 10, 1);
        expect_frame("b2b second", 12, {6'd0, 1'b1, 8'hAA, 1'b0}, 10, 1);
        check("b2b idle after", samp[22], 1);
        check("b2b busy drop", busy_s[22], 0);

        // Divisor change mid-frame affects only the next frame
        baud_div = 24'd9;
        tx_q = {8'h3C};
        drive_q();
        capture(103, 50, 24'd4);
        expect_frame("div9", 2, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 10);
        check("div9 busy drop", busy_s[102], 0);
        tx_q = {8'hC3};
        drive_q();
        capture(53, -1, 24'd0);
        expect_frame("div4", 2, {6'd0, 1'b1, 8'hC3, 1'b0}, 10, 5);
        check("div4 busy last", busy_s[51], 1);
        check("div4 busy drop", busy_s[52], 0);

        // Reset during data bit 3 with a word buffered
        baud_div = 24'd9;
        tx_q = {8'h00};
        drive_q();
        capture(45, -1, 24'd0);
        tx_q = {8'h81};
        drive_q();
        capture(1, -1, 24'd0);
        check("pre-reset d_out", uart_d_out, 0);
        check("pre-reset level", fifo_level, 1);
        check("pre-reset busy", uart_busy, 1);
        uart_reset = 1'b0;
        tick();
        check("abort d_out", uart_d_out, 1);
        check("abort ready", uart_ready, 1);
        check("abort level", fifo_level, 0);
        check("abort busy", uart_busy, 0);
        uart_reset = 1'b1;
        capture(20, -1, 24'd0);
        waited = 0;
        for (int k = 0; k < 20; k++) if (samp[k] === 1'b1 && busy_s[k] === 1'b0) waited++;
        check("post-reset idle clocks", waited, 20);

`ifdef UART_TX_FIFO_EN
        // Stalled line, five consecutive pushes into a depth-4 FIFO
        baud_div = 24'd99;
        tx_q = {8'hC1, 8'h12, 8'h23, 8'h34, 8'h45};
        drive_q();
        capture(5, -1, 24'd0);
        check("fifo all accepted", tx_q.size(), 0);
        check("fifo ready before 5th", ready_s[4], 1);
        check("fifo level full", fifo_level, 4);
        check("fifo ready full", uart_ready, 0);
        waited = 0;
        prev_ready = uart_ready;
        while (fifo_level != 3'd3 && waited < 1200) begin
            prev_ready = uart_ready;
            tick();
            waited++;
        end
        check("fifo pop seen", fifo_level, 3);
        check("fifo ready held before pop", prev_ready, 0);
        check("fifo ready after pop", uart_ready, 1);
        capture(4001, -1, 24'd0);
        expect_frame("fifo w1", 0, {6'd0, 1'b1, 8'h12, 1'b0}, 10, 100);
        expect_frame("fifo w2", 1000, {6'd0, 1'b1, 8'h23, 1'b0}, 10, 100);
        expect_frame("fifo w3", 2000, {6'd0, 1'b1, 8'h34, 1'b0}, 10, 100);
        expect_frame("fifo w4 wrapped", 3000, {6'd0, 1'b1, 8'h45, 1'b0}, 10, 100);
        check("fifo drained busy", busy_s[4000], 0);
        check("fifo drained level", level_s[4000], 0);
`else
        // Holding register: ready drops for one word, returns after the pop
        baud_div = 24'd99;
        tx_q = {8'hC1, 8'h12};
        drive_q();
        capture(3, -1, 24'd0);
        check("hold ready after push", ready_s[1], 0);
        check("hold level after push", level_s[1], 1);
        check("hold ready after pop", ready_s[2], 1);
        check("hold level after pop", level_s[2], 0);
        check("hold second accepted", tx_q.size(), 0);
        check("hold level full", fifo_level, 1);
        check("hold ready full", uart_ready, 0);
        do_reset();
        check("hold flushed level", fifo_level, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
